// File: rtl/vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_pattern_gen
// Description : RGB565 pixel source with four modes: colour bars, text bitmap,
//               centred image and bouncing image, with a fixed 2-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pattern_gen #(
    parameter int          H_ACTIVE = 640,
    parameter int          V_ACTIVE = 480,
    parameter int          ADDR_W   = 12,
    parameter int          BAR_NUM  = 8,
    parameter int          IMG_W    = 85,
    parameter int          IMG_H    = 85,
    parameter int          ROM_AW   = 14,
    parameter int          CHAR_W   = 384,
    parameter int          CHAR_H   = 64,
    parameter int          CHAR_AW  = 6,
    parameter int          CHAR_X0  = 148,
    parameter int          CHAR_Y0  = 208,
    parameter int          STEP     = 2,
    parameter logic [15:0] FG       = 16'hFFDF,
    parameter logic [15:0] BG       = 16'h0000
) (
    input  logic               vga_clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  addr_h,
    input  logic [ADDR_W-1:0]  addr_v,
    input  logic               frame_start,
    input  logic [2:0]         key,
    output logic [CHAR_AW-1:0] char_addr,
    input  logic [CHAR_W-1:0]  char_row,
    output logic [ROM_AW-1:0]  rom_addr,
    input  logic [15:0]        rom_data,
    output logic [15:0]        rgb_data,
    output logic [1:0]         mode
);

    localparam int AW1   = ADDR_W + 1;
    localparam int BIT_W = $clog2(CHAR_W);
    localparam int BAR_W = H_ACTIVE / BAR_NUM;

    localparam logic [AW1-1:0] C_H_ACT = AW1'(H_ACTIVE);
    localparam logic [AW1-1:0] C_V_ACT = AW1'(V_ACTIVE);
    localparam logic [AW1-1:0] C_TX0   = AW1'(CHAR_X0);
    localparam logic [AW1-1:0] C_TX1   = AW1'(CHAR_X0 + CHAR_W);
    localparam logic [AW1-1:0] C_TY0   = AW1'(CHAR_Y0);
    localparam logic [AW1-1:0] C_TY1   = AW1'(CHAR_Y0 + CHAR_H);
    localparam logic [AW1-1:0] C_IMG_W = AW1'(IMG_W);
    localparam logic [AW1-1:0] C_IMG_H = AW1'(IMG_H);
    localparam logic [AW1-1:0] C_ONE   = AW1'(1);

    localparam logic signed [AW1-1:0] C_ZERO  = '0;
    localparam logic signed [AW1-1:0] C_STEP  = AW1'(STEP);
    localparam logic signed [AW1-1:0] C_X_MAX = AW1'(H_ACTIVE - IMG_W);
    localparam logic signed [AW1-1:0] C_Y_MAX = AW1'(V_ACTIVE - IMG_H);
    localparam logic signed [AW1-1:0] C_X_CTR = AW1'((H_ACTIVE - IMG_W) / 2);
    localparam logic signed [AW1-1:0] C_Y_CTR = AW1'((V_ACTIVE - IMG_H) / 2);

    localparam logic [2:0] SEL_OFF = 3'd0;
    localparam logic [2:0] SEL_BG  = 3'd1;
    localparam logic [2:0] SEL_BAR = 3'd2;
    localparam logic [2:0] SEL_TXT = 3'd3;
    localparam logic [2:0] SEL_IMG = 3'd4;

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_colour = 16'hF800;
            3'd1:    bar_colour = 16'hFB80;
            3'd2:    bar_colour = 16'hFFC0;
            3'd3:    bar_colour = 16'h0400;
            3'd4:    bar_colour = 16'h001F;
            3'd5:    bar_colour = 16'h4810;
            3'd6:    bar_colour = 16'h8010;
            default: bar_colour = 16'hFFDF;
        endcase
    endfunction

    // ---------------- key synchroniser and edge detection ----------------
    logic [2:0] r_key_s1, r_key_s2, r_key_d;
    logic [2:0] w_key_rise;
    logic [1:0] r_pending;

    assign w_key_rise = r_key_s2 & ~r_key_d;

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_s1  <= '0;
            r_key_s2  <= '0;
            r_key_d   <= '0;
            r_pending <= 2'd0;
        end else begin
            r_key_s1 <= key;
            r_key_s2 <= r_key_s1;
            r_key_d  <= r_key_s2;
            if (w_key_rise[0])
                r_pending <= 2'd0;
            else if (w_key_rise[1])
                r_pending <= 2'd1;
            else if (w_key_rise[2])
                r_pending <= (r_pending == 2'd2) ? 2'd3 : 2'd2;
        end
    end

    // ---------------- frame-boundary mode commit and image position ------
    logic signed [AW1-1:0] r_x0, r_y0, r_dx, r_dy;
    logic signed [AW1-1:0] w_nx, w_ny;
    logic                  r_started;

    assign w_nx = r_x0 + r_dx;
    assign w_ny = r_y0 + r_dy;

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            mode      <= 2'd0;
            r_started <= 1'b0;
            r_x0      <= C_X_CTR;
            r_y0      <= C_Y_CTR;
            r_dx      <= C_STEP;
            r_dy      <= C_STEP;
        end else if (frame_start) begin
            mode      <= r_pending;
            r_started <= 1'b1;
            if (r_pending == 2'd2) begin
                r_x0 <= C_X_CTR;
                r_y0 <= C_Y_CTR;
            end else if (mode == 2'd3) begin
                if (w_nx <= C_ZERO) begin
                    r_x0 <= C_ZERO;
                    r_dx <= -r_dx;
                end else if (w_nx >= C_X_MAX) begin
                    r_x0 <= C_X_MAX;
                    r_dx <= -r_dx;
                end else begin
                    r_x0 <= w_nx;
                end
                if (w_ny <= C_ZERO) begin
                    r_y0 <= C_ZERO;
                    r_dy <= -r_dy;
                end else if (w_ny >= C_Y_MAX) begin
                    r_y0 <= C_Y_MAX;
                    r_dy <= -r_dy;
                end else begin
                    r_y0 <= w_ny;
                end
            end
        end
    end

    // ---------------- stage 1: windows, indices and ROM addresses --------
    logic [AW1-1:0]     w_h, w_v, w_x0u, w_y0u;
    logic [ADDR_W-1:0]  w_hm1, w_bar_q;
    logic [2:0]         w_bar_idx;
    logic               w_in_area, w_txt_win, w_img_win;
    logic [BIT_W-1:0]   w_bit;
    logic [2:0]         w_sel;

    assign w_h   = {1'b0, addr_h};
    assign w_v   = {1'b0, addr_v};
    assign w_x0u = $unsigned(r_x0);
    assign w_y0u = $unsigned(r_y0);
    assign w_hm1 = addr_h - 1'b1;
    assign w_bar_q   = w_hm1 / ADDR_W'(BAR_W);
    assign w_bar_idx = (w_bar_q >= ADDR_W'(BAR_NUM - 1)) ? 3'(BAR_NUM - 1) : w_bar_q[2:0];
    assign w_in_area = (addr_h != '0) && (addr_v != '0) && (w_h <= C_H_ACT) && (w_v <= C_V_ACT);
    assign w_txt_win = (w_h > C_TX0) && (w_h <= C_TX1) && (w_v > C_TY0) && (w_v <= C_TY1);
    assign w_img_win = (w_h > w_x0u) && (w_h <= w_x0u + C_IMG_W) &&
                       (w_v > w_y0u) && (w_v <= w_y0u + C_IMG_H);
    // Leftmost pixel maps to the MSB of the text row.
    assign w_bit = BIT_W'(C_TX1 - w_h);

    always_comb begin
        w_sel = SEL_BG;
        if (!r_started)
            w_sel = SEL_OFF;
        else if (w_in_area) begin
            case (mode)
                2'd0:    w_sel = SEL_BAR;
                2'd1:    w_sel = w_txt_win ? SEL_TXT : SEL_BG;
                default: w_sel = w_img_win ? SEL_IMG : SEL_BG;
            endcase
        end
    end

    logic [2:0]       r_sel;
    logic [2:0]       r_bar_idx;
    logic [BIT_W-1:0] r_bit;

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel     <= SEL_OFF;
            r_bar_idx <= 3'd0;
            r_bit     <= '0;
            char_addr <= '0;
            rom_addr  <= '0;
        end else begin
            r_sel     <= w_sel;
            r_bar_idx <= w_bar_idx;
            r_bit     <= w_bit;
            if (mode == 2'd1 && w_txt_win)
                char_addr <= CHAR_AW'(w_v - C_TY0 - C_ONE);
            // Address derived from coordinates only, so it cannot drift between frames.
            if (mode[1] && w_img_win)
                rom_addr <= ROM_AW'(w_v - w_y0u - C_ONE) * ROM_AW'(IMG_W) +
                            ROM_AW'(w_h - w_x0u - C_ONE);
        end
    end

    // ---------------- stage 2: colour select -----------------------------
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_data <= 16'h0000;
        end else begin
            case (r_sel)
                SEL_OFF: rgb_data <= 16'h0000;
                SEL_BAR: rgb_data <= bar_colour(r_bar_idx);
                SEL_TXT: rgb_data <= char_row[r_bit] ? FG : BG;
                SEL_IMG: rgb_data <= rom_data;
                default: rgb_data <= BG;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_pattern_gen
// Description : Directed scoreboard bench for vga_pattern_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_pattern_gen;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int IMG_W    = 85;
    localparam int IMG_H    = 85;

    logic         vga_clk;
    logic         rst_n;
    logic [11:0]  addr_h, addr_v;
    logic         frame_start;
    logic [2:0]   key;
    logic [5:0]   char_addr;
    logic [383:0] char_row;
    logic [13:0]  rom_addr;
    logic [15:0]  rom_data;
    logic [15:0]  rgb_data;
    logic [1:0]   mode;

    int checks;
    int errors;

    logic        chk_q[$];
    logic [15:0] exp_q[$];
    string       tag_q[$];

    int         mx, my, mdx, mdy;
    logic [1:0] m_mode, m_pend;

    vga_pattern_gen dut (
        .vga_clk    (vga_clk),
        .rst_n      (rst_n),
        .addr_h     (addr_h),
        .addr_v     (addr_v),
        .frame_start(frame_start),
        .key        (key),
        .char_addr  (char_addr),
        .char_row   (char_row),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .rgb_data   (rgb_data),
        .mode       (mode)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // ROM models: data follows the address register combinationally.
    assign rom_data = {2'b00, rom_addr};
    assign char_row = (char_addr == 6'd0) ? {384{1'b1}} : {192{2'b10}};

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int h, input int v, input logic fs, input logic chk,
                        input logic [15:0] exp, input string tag);
        logic        c;
        logic [15:0] e;
        string       t;
        @(posedge vga_clk);
        #1;
        if (chk_q.size() == 2) begin
            c = chk_q.pop_front();
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            if (c) check(t, rgb_data, e);
        end
        addr_h      = 12'(h);
        addr_v      = 12'(v);
        frame_start = fs;
        chk_q.push_back(chk);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    task automatic px(input int h, input int v, input logic [15:0] e, input string t);
        step(h, v, 1'b0, 1'b1, e, t);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1'b0, 1'b0, 16'h0000, "idle");
    endtask

    task automatic press(input int k);
        key[k] = 1'b1;
        idle(4);
        key[k] = 1'b0;
        idle(4);
    endtask

    task automatic bounce(inout int p, inout int d, input int lim);
        p = p + d;
        if (p <= 0) begin
            p = 0;
            d = -d;
        end else if (p >= lim) begin
            p = lim;
            d = -d;
        end
    endtask

    task automatic frame();
        if (m_pend == 2'd2) begin
            mx = (H_ACTIVE - IMG_W) / 2;
            my = (V_ACTIVE - IMG_H) / 2;
        end else if (m_mode == 2'd3) begin
            bounce(mx, mdx, H_ACTIVE - IMG_W);
            bounce(my, mdy, V_ACTIVE - IMG_H);
        end
        m_mode = m_pend;
        step(0, 0, 1'b1, 1'b0, 16'h0000, "fs");
        step(0, 0, 1'b0, 1'b0, 16'h0000, "idle");
    endtask

    // Image ROM returns its own address, so pixel value reveals window origin.
    task automatic check_pos(input int ex, input int ey);
        px(ex,      ey + 2, 16'h0000,      "img_left_edge");
        px(ex + 1,  ey + 2, 16'(IMG_W),     "img_col0");
        px(ex + 2,  ey + 2, 16'(IMG_W + 1), "img_col1");
        px(ex + 85, ey + 2, 16'(IMG_W + 84), "img_col84");
        px(ex + 86, ey + 2, 16'h0000,      "img_right_edge");
    endtask

    function automatic logic [15:0] bar_exp(input int h);
        int idx;
        if (h == 0 || h > H_ACTIVE) return 16'h0000;
        idx = (h - 1) / 80;
        if (idx > 7) idx = 7;
        case (idx)
            0:       return 16'hF800;
            1:       return 16'hFB80;
            2:       return 16'hFFC0;
            3:       return 16'h0400;
            4:       return 16'h001F;
            5:       return 16'h4810;
            6:       return 16'h8010;
            default: return 16'hFFDF;
        endcase
    endfunction

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; addr_h = '0; addr_v = '0; frame_start = 1'b0; key = '0;
        m_mode = 2'd0; m_pend = 2'd0;
        mx = 277; my = 197; mdx = 2; mdy = 2;

        repeat (3) @(posedge vga_clk);
        #1;
        check("rst_rgb",       rgb_data,        16'h0000);
        check("rst_mode",      16'(mode),      16'd0);
        check("rst_char_addr", 16'(char_addr), 16'd0);
        check("rst_rom_addr",  16'(rom_addr),  16'd0);
        #2 rst_n = 1'b1;

        // dark until the first frame_start
        px(100, 1, 16'h0000, "pre_frame_dark");
        px(300, 100, 16'h0000, "pre_frame_dark2");
        frame();
        for (int h = 0; h <= 641; h++) px(h, 1, bar_exp(h), "bar_sweep");
        idle(2);

        // text mode, committed only at frame_start
        press(1);
        m_pend = 2'd1;
        check("mode_hold_mid_frame", 16'(mode), 16'd0);
        frame();
        check("mode_text", 16'(mode), 16'd1);
        px(149, 209, 16'hFFDF, "txt_first");
        px(148, 209, 16'h0000, "txt_left_out");
        px(532, 209, 16'hFFDF, "txt_last");
        px(533, 209, 16'h0000, "txt_right_out");
        px(149, 210, 16'hFFDF, "txt_msb_row1");
        px(150, 210, 16'h0000, "txt_bit382_row1");
        px(149, 208, 16'h0000, "txt_above");
        px(149, 273, 16'h0000, "txt_below");
        px(200, 209, 16'hFFDF, "txt_row0");
        idle(1);
        check("char_addr_row0", 16'(char_addr), 16'd0);
        px(200, 272, 16'h0000, "txt_row63");
        idle(1);
        check("char_addr_row63", 16'(char_addr), 16'd63);
        idle(2);

        // static image
        press(2);
        m_pend = 2'd2;
        frame();
        check("mode_static", 16'(mode), 16'd2);
        px(278, 198, 16'd0, "img_origin");
        idle(1);
        check("rom_addr_origin", 16'(rom_addr), 16'd0);
        px(362, 198, 16'd84, "img_top_right");
        idle(1);
        check("rom_addr_top_right", 16'(rom_addr), 16'd84);
        px(362, 282, 16'd7224, "img_bottom_right");
        idle(1);
        check("rom_addr_bottom_right", 16'(rom_addr), 16'd7224);
        px(277, 198, 16'h0000, "img_left_out");
        px(300, 250, 16'd4442, "img_mid");
        px(363, 250, 16'h0000, "img_right_out");
        idle(1);
        check("rom_addr_hold", 16'(rom_addr), 16'd4442);
        idle(2);

        // bounce
        press(2);
        m_pend = 2'd3;
        frame();
        check("mode_bounce", 16'(mode), 16'd3);
        check_pos(mx, my);
        for (int f = 0; f < 145; f++) begin
            frame();
            check_pos(mx, my);
        end
        idle(2);

        // simultaneous key[0] and key[2]: key[0] wins
        key = 3'b101;
        idle(4);
        key = 3'b000;
        idle(4);
        m_pend = 2'd0;
        frame();
        check("mode_simul_keys", 16'(mode), 16'd0);
        px(1, 1, 16'hF800, "bars_back");

        // long hold of key[2]: exactly one transition
        key[2] = 1'b1;
        idle(1000);
        m_pend = 2'd2;
        check("mode_before_commit", 16'(mode), 16'd0);
        frame();
        check("mode_held_key", 16'(mode), 16'd2);
        key[2] = 1'b0;
        idle(4);
        frame();
        check("mode_held_key_again", 16'(mode), 16'd2);
        check_pos(mx, my);
        idle(2);

        // reset while bouncing
        press(2);
        m_pend = 2'd3;
        frame();
        frame();
        check("mode_bounce2", 16'(mode), 16'd3);
        check_pos(mx, my);
        px(mx + 2, my + 2, 16'(IMG_W + 1), "img_pre_reset");
        step(mx + 3, my + 2, 1'b0, 1'b0, 16'h0000, "idle");
        step(mx + 4, my + 2, 1'b0, 1'b0, 16'h0000, "idle");
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_rgb",  rgb_data,   16'h0000);
        check("async_rst_mode", 16'(mode), 16'd0);
        chk_q.delete(); exp_q.delete(); tag_q.delete();
        addr_h = '0; addr_v = '0;
        repeat (2) @(posedge vga_clk);
        #3 rst_n = 1'b1;
        m_mode = 2'd0; m_pend = 2'd0;
        mx = 277; my = 197; mdx = 2; mdy = 2;
        px(100, 1, 16'h0000, "post_rst_dark");
        px(200, 5, 16'h0000, "post_rst_dark2");
        frame();
        px(1, 1, 16'hF800, "post_rst_bar_first");
        px(640, 1, 16'hFFDF, "post_rst_bar_last");
        idle(2);
        press(2);
        press(2);
        m_pend = 2'd3;
        frame();
        check("mode_bounce_after_rst", 16'(mode), 16'd3);
        check_pos(mx, my);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
